lc3_mem_ctrl: RTL and testbench

- Memory/I-O controller between the LC-3 control FSM (MAR, MDR, MIO.EN, R.W) and the 128-word synchronous data memory.
- Decodes each access to memory, the memory-mapped keyboard/display registers, or an unmapped address.
- Sequences the 1-cycle-latency memory read, inserts optional wait states, and returns the LC-3 ready bit R.
- Owns the KBSR/KBDR/DSR/DDR registers and the keyboard and display handshakes.

---
 rtl/lc3_mem_pkg.sv | 38 +++
 rtl/lc3_io_regs.sv | 82 ++++++++
 rtl/lc3_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory/I-O controller.
// The optional keyboard interrupt enable is controlled by LC3_MEMCTL_IRQ_EN.
package lc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        IO,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_KBSR,
        SEL_KBDR,
        SEL_DSR,
        SEL_DDR
    } io_sel_t;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    function automatic io_sel_t decode_io(input logic [15:0] addr);
        io_sel_t sel;
        case (addr)
            ADDR_KBSR: sel = SEL_KBSR;
            ADDR_KBDR: sel = SEL_KBDR;
            ADDR_DSR:  sel = SEL_DSR;
            ADDR_DDR:  sel = SEL_DDR;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/lc3_io_regs.sv
// Keyboard/display device registers and their handshakes.
// With LC3_MEMCTL_IRQ_EN defined, KBSR[14] is a writable interrupt enable.
module lc3_io_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    input  logic        dsp_ready,
    input  logic        rd_kbdr,
    input  logic        wr_kbsr,
    input  logic        wr_ddr,
    input  logic [15:0] wr_data,
    output logic [15:0] kbsr,
    output logic [15:0] kbdr,
    output logic [15:0] dsr,
    output logic [15:0] ddr,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    output logic        kb_irq
);

    logic        kb_ready_reg;
    logic [15:0] kbdr_reg;
    logic [15:0] ddr_reg;
    logic        dsp_valid_reg;
    logic        irq_en;

    always_ff @(posedge clk) begin
        if (srst) begin
            kb_ready_reg  <= 1'b0;
            kbdr_reg      <= 16'h0000;
            ddr_reg       <= 16'h0000;
            dsp_valid_reg <= 1'b0;
        end else begin
            // A new character beats a simultaneous KBDR read, so it is never lost.
            if (kb_valid) begin
                kb_ready_reg <= 1'b1;
                kbdr_reg     <= {8'h00, kb_data};
            end else if (rd_kbdr) begin
                kb_ready_reg <= 1'b0;
            end

            if (wr_ddr && !dsp_valid_reg) begin
                ddr_reg       <= wr_data;
                dsp_valid_reg <= 1'b1;
            end else if (dsp_valid_reg && dsp_ready) begin
                dsp_valid_reg <= 1'b0;
            end
        end
    end

`ifdef LC3_MEMCTL_IRQ_EN
    logic irq_en_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            irq_en_reg <= 1'b0;
        end else if (wr_kbsr) begin
            irq_en_reg <= wr_data[14];
        end
    end

    assign irq_en = irq_en_reg;
    assign kb_irq = kb_ready_reg & irq_en_reg;
`else
    logic unused_kbsr_wr;

    assign unused_kbsr_wr = wr_kbsr;
    assign irq_en         = 1'b0;
    assign kb_irq         = 1'b0;
`endif

    assign kbsr      = {kb_ready_reg, irq_en, 14'h0000};
    assign kbdr      = kbdr_reg;
    assign dsr       = {!dsp_valid_reg, 15'h0000};
    assign ddr       = ddr_reg;
    assign dsp_valid = dsp_valid_reg;
    assign dsp_data  = ddr_reg[7:0];

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/I-O controller: decodes MAR, sequences memory and device
// accesses, returns R. Optional feature macro: LC3_MEMCTL_IRQ_EN.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int MEM_AW      = 7,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mio_en,
    input  logic              r_w,
    input  logic [15:0]       mar,
    input  logic [15:0]       mdr_in,
    output logic [15:0]       mdr_out,
    output logic              ready,
    output logic              err,
    output logic              mem_we,
    output logic              mem_re,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_d,
    input  logic [15:0]       mem_q,
    input  logic              kb_valid,
    input  logic [7:0]        kb_data,
    output logic              dsp_valid,
    output logic [7:0]        dsp_data,
    input  logic              dsp_ready,
    output logic              kb_irq
);

    state_t            state_reg, state_next;
    logic [MEM_AW-1:0] mar_reg;
    logic              rw_reg;
    logic [15:0]       mdr_reg;
    io_sel_t           sel_reg;
    logic              err_reg;
    logic [3:0]        wait_cnt_reg;
    logic [15:0]       mdr_out_reg;

    logic              is_mem;
    io_sel_t           sel_in;
    logic [15:0]       io_rdata;
    logic [15:0]       kbsr, kbdr, dsr, ddr;
    logic              rd_kbdr, wr_kbsr, wr_ddr;

    assign is_mem = (mar[15:MEM_AW] == '0);
    assign sel_in = decode_io(mar);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mio_en) state_next = is_mem ? ACCESS : IO;
            ACCESS:  state_next = WAIT;
            WAIT:    if (wait_cnt_reg == 4'd0) state_next = DONE;
            IO:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            mar_reg      <= '0;
            rw_reg       <= 1'b0;
            mdr_reg      <= 16'h0000;
            sel_reg      <= SEL_NONE;
            err_reg      <= 1'b0;
            wait_cnt_reg <= 4'd0;
            mdr_out_reg  <= 16'h0000;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (mio_en) begin
                        mar_reg <= mar[MEM_AW-1:0];
                        rw_reg  <= r_w;
                        mdr_reg <= mdr_in;
                        sel_reg <= sel_in;
                        err_reg <= !is_mem && (sel_in == SEL_NONE);
                    end
                end
                ACCESS: wait_cnt_reg <= 4'(WAIT_CYCLES);
                WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        if (!rw_reg) mdr_out_reg <= mem_q;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                IO: begin
                    if (!rw_reg) mdr_out_reg <= io_rdata;
                    // Display still busy: the DDR write is dropped and reported.
                    if (rw_reg && (sel_reg == SEL_DDR) && dsp_valid) err_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        io_rdata = 16'h0000;
        case (sel_reg)
            SEL_KBSR: io_rdata = kbsr;
            SEL_KBDR: io_rdata = kbdr;
            SEL_DSR:  io_rdata = dsr;
            SEL_DDR:  io_rdata = ddr;
            default:  io_rdata = 16'h0000;
        endcase
    end

    assign rd_kbdr = (state_reg == IO) && !rw_reg && (sel_reg == SEL_KBDR);
    assign wr_kbsr = (state_reg == IO) && rw_reg && (sel_reg == SEL_KBSR);
    assign wr_ddr  = (state_reg == IO) && rw_reg && (sel_reg == SEL_DDR);

    lc3_io_regs u_io_regs (
        .clk       (clk),
        .srst      (rst),
        .kb_valid  (kb_valid),
        .kb_data   (kb_data),
        .dsp_ready (dsp_ready),
        .rd_kbdr   (rd_kbdr),
        .wr_kbsr   (wr_kbsr),
        .wr_ddr    (wr_ddr),
        .wr_data   (mdr_reg),
        .kbsr      (kbsr),
        .kbdr      (kbdr),
        .dsr       (dsr),
        .ddr       (ddr),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .kb_irq    (kb_irq)
    );

    assign mem_we   = (state_reg == ACCESS) && rw_reg;
    assign mem_re   = (state_reg == ACCESS) && !rw_reg;
    assign mem_addr = mar_reg;
    assign mem_d    = mdr_reg;
    assign mdr_out  = mdr_out_reg;
    assign ready    = (state_reg == DONE);
    assign err      = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: dut0 has no wait states, dut1 has three.
// Both share the request bus; each has its own 128-word memory model.
module tb_lc3_mem_ctrl;
    import lc3_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mio_en = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] mar = 16'h0000;
    logic [15:0] mdr_in = 16'h0000;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic        dsp_ready = 1'b0;

    logic [15:0] mdr_out0, mdr_out1, mem_d0, mem_d1;
    logic [15:0] mem_q0 = 16'h0000;
    logic [15:0] mem_q1 = 16'h0000;
    logic        ready0, ready1, err0, err1;
    logic        mem_we0, mem_we1, mem_re0, mem_re1;
    logic [6:0]  mem_addr0, mem_addr1;
    logic        dsp_valid0, dsp_valid1, kb_irq0, kb_irq1;
    logic [7:0]  dsp_data0, dsp_data1;

    logic [15:0] mem0 [128];
    logic [15:0] mem1 [128];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_mem_ctrl #(.MEM_AW(7), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mio_en(mio_en), .r_w(r_w), .mar(mar), .mdr_in(mdr_in),
        .mdr_out(mdr_out0), .ready(ready0), .err(err0), .mem_we(mem_we0), .mem_re(mem_re0),
        .mem_addr(mem_addr0), .mem_d(mem_d0), .mem_q(mem_q0), .kb_valid(kb_valid),
        .kb_data(kb_data), .dsp_valid(dsp_valid0), .dsp_data(dsp_data0),
        .dsp_ready(dsp_ready), .kb_irq(kb_irq0)
    );

    lc3_mem_ctrl #(.MEM_AW(7), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .mio_en(mio_en), .r_w(r_w), .mar(mar), .mdr_in(mdr_in),
        .mdr_out(mdr_out1), .ready(ready1), .err(err1), .mem_we(mem_we1), .mem_re(mem_re1),
        .mem_addr(mem_addr1), .mem_d(mem_d1), .mem_q(mem_q1), .kb_valid(kb_valid),
        .kb_data(kb_data), .dsp_valid(dsp_valid1), .dsp_data(dsp_data1),
        .dsp_ready(dsp_ready), .kb_irq(kb_irq1)
    );

    always @(posedge clk) begin
        if (mem_we0) mem0[mem_addr0] <= mem_d0;
        if (mem_re0) mem_q0 <= mem0[mem_addr0];
        if (mem_we1) mem1[mem_addr1] <= mem_d1;
        if (mem_re1) mem_q1 <= mem1[mem_addr1];
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one access in the current cycle (cycle 0) and watches the chosen DUT
    // until ready; cycle numbers returned are relative to cycle 0, -1 if none.
    task automatic do_access(input int which, input logic rw, input logic [15:0] addr,
                             input logic [15:0] data, input logic kb_pulse,
                             input logic [7:0] kb_char, output int rdy_cyc,
                             output logic [15:0] rdata, output logic err_v,
                             output int strobe_cnt, output int last_strobe);
        logic s_rdy, s_err, s_we, s_re, found;
        logic [15:0] s_q;
        mar = addr; r_w = rw; mdr_in = data; mio_en = 1'b1;
        rdy_cyc = -1; rdata = 16'hxxxx; err_v = 1'bx;
        strobe_cnt = 0; last_strobe = -1; found = 1'b0;
        for (int c = 1; c <= 40 && !found; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                mio_en = 1'b0;
                kb_valid = kb_pulse;
                kb_data = kb_char;
            end else begin
                kb_valid = 1'b0;
            end
            if (which == 0) begin
                s_rdy = ready0; s_err = err0; s_we = mem_we0; s_re = mem_re0; s_q = mdr_out0;
            end else begin
                s_rdy = ready1; s_err = err1; s_we = mem_we1; s_re = mem_re1; s_q = mdr_out1;
            end
            if (s_we || s_re) begin
                strobe_cnt++;
                last_strobe = c;
            end
            if (s_rdy) begin
                rdy_cyc = c; rdata = s_q; err_v = s_err; found = 1'b1;
            end
        end
        kb_valid = 1'b0;
        $display("txn dut%0d %s addr=%h wdata=%h ready@%0d rdata=%h err=%b strobes=%0d",
                 which, rw ? "WR" : "RD", addr, data, rdy_cyc, rdata, err_v, strobe_cnt);
    endtask

    int          rc, sc, ls;
    logic [15:0] rd;
    logic        ev;

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err0); end
        checks++; if ({mem_we0, mem_re0} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b want=00", {mem_we0, mem_re0}); end
        checks++; if (dsp_valid0 !== 1'b0) begin errors++; $display("FAIL reset_dsp_valid got=%b want=0", dsp_valid0); end
        checks++; if (kb_irq0 !== 1'b0) begin errors++; $display("FAIL reset_kb_irq got=%b want=0", kb_irq0); end
        checks++; if (mdr_out0 !== 16'h0000) begin errors++; $display("FAIL reset_mdr_out got=%h want=0000", mdr_out0); end
    endtask

    task automatic test_mem_rw();
        do_access(0, 1'b1, 16'h0005, 16'h1234, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rc !== 3) begin errors++; $display("FAIL wr_ready_cycle got=%0d want=3", rc); end
        checks++; if (sc !== 1 || ls !== 1) begin errors++; $display("FAIL wr_strobe got=%0d@%0d want=1@1", sc, ls); end
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL wr_err got=%b want=0", ev); end
        checks++; if (mem0[5] !== 16'h1234) begin errors++; $display("FAIL wr_mem got=%h want=1234", mem0[5]); end
        idle(5);
        do_access(0, 1'b0, 16'h0005, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rc !== 3) begin errors++; $display("FAIL rd_ready_cycle got=%0d want=3", rc); end
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL rd_data got=%h want=1234", rd); end
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL rd_err got=%b want=0", ev); end
        idle(5);
        do_access(0, 1'b1, 16'h007F, 16'h7F7F, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        idle(5);
        do_access(0, 1'b0, 16'h007F, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h7F7F || rc !== 3) begin errors++; $display("FAIL top_word got=%h@%0d want=7f7f@3", rd, rc); end
        idle(5);
    endtask

    task automatic test_wait_states();
        do_access(0, 1'b1, 16'h0010, 16'h0BAD, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        idle(6);
        do_access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rc !== 6) begin errors++; $display("FAIL wait_ready_cycle got=%0d want=6", rc); end
        checks++; if (sc !== 1 || ls !== 1) begin errors++; $display("FAIL wait_strobe got=%0d@%0d want=1@1", sc, ls); end
        checks++; if (rd !== 16'h0BAD) begin errors++; $display("FAIL wait_data got=%h want=0bad", rd); end
        idle(3);
    endtask

    task automatic test_keyboard();
        kb_data = 8'h41; kb_valid = 1'b1;
        idle(1);
        kb_valid = 1'b0;
        do_access(0, 1'b0, ADDR_KBSR, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h8000 || rc !== 2) begin errors++; $display("FAIL kbsr_set got=%h@%0d want=8000@2", rd, rc); end
        idle(1);
        do_access(0, 1'b0, ADDR_KBDR, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h0041) begin errors++; $display("FAIL kbdr_read got=%h want=0041", rd); end
        idle(1);
        do_access(0, 1'b0, ADDR_KBSR, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL kbsr_clear got=%h want=0000", rd); end
        // New character lands on the same edge as the KBDR read clears KBSR.
        kb_data = 8'h41; kb_valid = 1'b1;
        idle(1);
        kb_valid = 1'b0;
        do_access(0, 1'b0, ADDR_KBDR, 16'h0000, 1'b1, 8'h42, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h0041) begin errors++; $display("FAIL kb_race_old got=%h want=0041", rd); end
        idle(1);
        do_access(0, 1'b0, ADDR_KBSR, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL kb_race_sr got=%h want=8000", rd); end
        idle(1);
        do_access(0, 1'b0, ADDR_KBDR, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h0042) begin errors++; $display("FAIL kb_race_new got=%h want=0042", rd); end
        idle(1);
        do_access(0, 1'b1, ADDR_KBDR, 16'hFFFF, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (ev !== 1'b0 || rc !== 2) begin errors++; $display("FAIL kbdr_write_ignored err=%b@%0d want=0@2", ev, rc); end
        idle(1);
        do_access(0, 1'b1, ADDR_KBSR, 16'hFFFF, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        idle(1);
        do_access(0, 1'b0, ADDR_KBSR, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
`ifdef LC3_MEMCTL_IRQ_EN
        checks++; if (rd !== 16'h4000) begin errors++; $display("FAIL kbsr_write got=%h want=4000", rd); end
`else
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL kbsr_write got=%h want=0000", rd); end
`endif
        idle(2);
    endtask

    task automatic test_display();
        dsp_ready = 1'b0;
        do_access(0, 1'b1, ADDR_DDR, 16'h0048, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (ev !== 1'b0 || rc !== 2) begin errors++; $display("FAIL ddr_write err=%b@%0d want=0@2", ev, rc); end
        checks++; if (dsp_valid0 !== 1'b1 || dsp_data0 !== 8'h48) begin errors++; $display("FAIL dsp_out got=%b/%h want=1/48", dsp_valid0, dsp_data0); end
        idle(1);
        do_access(0, 1'b0, ADDR_DSR, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL dsr_busy got=%h want=0000", rd); end
        idle(1);
        do_access(0, 1'b1, ADDR_DDR, 16'h0055, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (ev !== 1'b1 || rc !== 2) begin errors++; $display("FAIL ddr_drop err=%b@%0d want=1@2", ev, rc); end
        checks++; if (dsp_data0 !== 8'h48) begin errors++; $display("FAIL ddr_kept got=%h want=48", dsp_data0); end
        idle(1);
        do_access(0, 1'b0, ADDR_DDR, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h0048) begin errors++; $display("FAIL ddr_read got=%h want=0048", rd); end
        dsp_ready = 1'b1;
        idle(1);
        dsp_ready = 1'b0;
        checks++; if (dsp_valid0 !== 1'b0) begin errors++; $display("FAIL dsp_accept got=%b want=0", dsp_valid0); end
        do_access(0, 1'b0, ADDR_DSR, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL dsr_free got=%h want=8000", rd); end
        idle(2);
    endtask

    task automatic test_unmapped();
        do_access(0, 1'b0, 16'h3000, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rc !== 2 || ev !== 1'b1) begin errors++; $display("FAIL unmap_rd got=%0d/%b want=2/1", rc, ev); end
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL unmap_rd_data got=%h want=0000", rd); end
        idle(1);
        do_access(0, 1'b1, 16'hFE10, 16'hDEAD, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rc !== 2 || ev !== 1'b1 || sc !== 0) begin errors++; $display("FAIL unmap_wr got=%0d/%b/%0d want=2/1/0", rc, ev, sc); end
        idle(1);
        do_access(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rd !== 16'h0BAD) begin errors++; $display("FAIL unmap_mem_intact got=%h want=0bad", rd); end
        idle(1);
        do_access(0, 1'b0, 16'h0080, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rc !== 2 || ev !== 1'b1 || sc !== 0) begin errors++; $display("FAIL unmap_0080 got=%0d/%b/%0d want=2/1/0", rc, ev, sc); end
        idle(6);
    endtask

    task automatic test_back_to_back();
        do_access(0, 1'b0, 16'h0005, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        idle(1);
        do_access(0, 1'b0, ADDR_DSR, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rc !== 2 || rd !== 16'h8000) begin errors++; $display("FAIL b2b got=%0d/%h want=2/8000", rc, rd); end
        idle(8);
    endtask

    task automatic test_reset_mid();
        int late_ready;
        mar = 16'h0005; r_w = 1'b0; mio_en = 1'b1;
        idle(1);
        mio_en = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++; if (dut0.state_reg !== IDLE) begin errors++; $display("FAIL rst_mid_state got=%0d want=IDLE", dut0.state_reg); end
        late_ready = 0;
        for (int i = 0; i < 5; i++) begin
            if (ready0 === 1'b1) late_ready++;
            idle(1);
        end
        checks++; if (late_ready !== 0) begin errors++; $display("FAIL rst_mid_ready got=%0d pulses want=0", late_ready); end
        do_access(0, 1'b0, 16'h0005, 16'h0000, 1'b0, 8'h00, rc, rd, ev, sc, ls);
        checks++; if (rc !== 3 || rd !== 16'h1234) begin errors++; $display("FAIL rst_mid_next got=%0d/%h want=3/1234", rc, rd); end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_mem_rw();
        test_wait_states();
        test_keyboard();
        test_display();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
